// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and defaults.
package capture_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARM     = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_FULL    = 2'd3;

    // The first conversion after enabling the ADC host is stale.
    localparam int DISCARD_DEFAULT = 1;

    // Capture owns the ADC and the SRAM port in these states.
    function automatic logic is_busy(input state_t s);
        return (s == ST_ARM) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/capture_decimator.sv
// Integer decimator: keeps one of every dec+1 strobes; dec is latched on load.
module capture_decimator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] dec,
    input  logic       strobe,
    output logic       keep
);

    logic [3:0] dec_q;
    logic [3:0] dec_cnt;

    assign keep = strobe && (dec_cnt == '0);

    // Latch the ratio on load; otherwise count strobes, wrapping at the latched ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            dec_cnt <= '0;
        end else if (load) begin
            dec_q   <= dec;
            dec_cnt <= '0;
        end else if (strobe) begin
            dec_cnt <= (dec_cnt == dec_q) ? '0 : dec_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// One-shot ADC capture into a single-port SRAM, with readout arbitration.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DISCARD = DISCARD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_lvl,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [3:0]        dec,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              adc_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              full,
    output logic              busy,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   count
);

    localparam logic [31:0]     DISCARD_U = DISCARD;
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            next_state;
    logic              start_q;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       disc_cnt;
    logic              arm_entry;
    logic              disc_last;
    logic              strobe;
    logic              keep;
    logic              accept;

    assign arm_entry = (next_state == ST_ARM) && (state != ST_ARM);
    assign disc_last = ({16'd0, disc_cnt} + 32'd1) >= DISCARD_U;
    assign strobe    = (state == ST_CAPTURE) && adc_valid;
    assign accept    = keep && start_lvl;

    capture_decimator u_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (arm_entry),
        .dec    (dec),
        .strobe (strobe),
        .keep   (keep)
    );

    // Next-state logic; abort (start_lvl low) wins over any concurrent sample.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_lvl) next_state = ST_ARM;
            end
            ST_ARM: begin
                if (!start_lvl)
                    next_state = ST_IDLE;
                else if ((DISCARD_U == '0) || (adc_valid && disc_last))
                    next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!start_lvl)
                    next_state = ST_IDLE;
                else if (accept && (wp == '1))
                    next_state = ST_FULL;
            end
            ST_FULL: begin
                if (start_lvl && !start_q) next_state = ST_ARM;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, registered status outputs and start_lvl history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            adc_en  <= 1'b0;
            full    <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start_lvl;
            adc_en  <= is_busy(next_state);
            full    <= (next_state == ST_FULL);
        end
    end

    // Discard counter: cleared on arming, counts strobes while armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc_cnt <= '0;
        end else if (arm_entry) begin
            disc_cnt <= '0;
        end else if ((state == ST_ARM) && adc_valid) begin
            disc_cnt <= disc_cnt + 16'd1;
        end
    end

    // Write path: one registered write per accepted sample; pointer and count never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_wen   <= 1'b0;
            sram_wdata <= '0;
            waddr      <= '0;
            wp         <= '0;
            count      <= '0;
        end else begin
            sram_wen <= accept;
            if (arm_entry) begin
                wp    <= '0;
                count <= '0;
            end else if (accept) begin
                sram_wdata <= adc_data;
                waddr      <= wp;
                if (wp != '1) wp <= wp + ADDR_W'(1);
                if (count != COUNT_MAX) count <= count + (ADDR_W + 1)'(1);
            end
        end
    end

    // The pending write keeps the port for its own cycle even after FULL or abort.
    assign busy      = is_busy(state);
    assign state_o   = state;
    assign sram_addr = (busy || sram_wen) ? waddr : rd_addr;

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one-shot ADC captures into the sample SRAM and arbitrates that SRAM's single port between the capture write path and the host readout path. Sits between the ADC host (sample strobe/data), the serial readout block (read address and "host done" level) and the 64k×16 single-port SRAM. Adds configurable start-of-capture discard and integer decimation. Exports full/busy status for the LEDs.

## Interface
- ADDR_W, 16, SRAM address width; depth = 2^ADDR_W
- DATA_W, 16, sample/SRAM data width
- DISCARD, 1, valid samples dropped after arming (stale first conversion)
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous, active-low reset
- start_lvl  in  1  readout "done" level, clk domain; high = host idle, capture allowed
- adc_valid  in  1  one-cycle new-sample strobe from ADC host
- adc_data  in  DATA_W  sample, valid with adc_valid
- dec  in  4  decimation: keep 1 of every dec+1 samples; sampled on ARM entry
- rd_addr  in  ADDR_W  readout address
- adc_en  out  1  enable to ADC host
- sram_wen  out  1  SRAM write enable
- sram_addr  out  ADDR_W  muxed SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- full  out  1  buffer holds a complete capture
- busy  out  1  state is ARM or CAPTURE
- state_o  out  2  current state encoding
- count  out  ADDR_W+1  samples written in current capture

## Operation
- States: IDLE(0), ARM(1), CAPTURE(2), FULL(3). Reset → IDLE; all outputs 0, counters 0.
- IDLE: start_lvl high → ARM (level-sensitive).
- ARM: adc_en=1; latch dec; clear count, write pointer, decimation counter, discard counter. Count DISCARD adc_valid strobes, data dropped; on the DISCARD-th strobe → CAPTURE. DISCARD=0 → CAPTURE next cycle.
- CAPTURE: on adc_valid with dec_cnt==0 → write accepted: next cycle sram_wen=1, sram_wdata=adc_data, write address=wp; wp++, count++. dec_cnt wraps at latched dec (0..dec). Accepted write at wp=2^ADDR_W−1 → FULL; adc_en drops same edge.
- FULL: adc_en=0, full=1. Rising edge of start_lvl (registered compare) → ARM, full cleared. Level alone does not retrigger.
- Abort: start_lvl low in ARM or CAPTURE → IDLE, adc_en=0, full=0, count retained.
- Port ownership: capture owns when state∈{ARM,CAPTURE} or sram_wen=1; then sram_addr = registered write address, else rd_addr. sram_wen never asserted when readout owns.
- Width: wp is ADDR_W bits, no wrap past last address; count saturates at 2^ADDR_W.

## Timing
- adc_en registered: high first cycle in ARM, low first cycle in FULL/IDLE.
- adc_valid → sram_wen/data/address: 1 cycle, single-cycle pulse.
- Last write's sram_wen coincides with first FULL cycle; ownership held that cycle; full visible that same cycle.
- Back-to-back adc_valid every cycle supported (dec=0), one write per cycle.
- start_lvl rise in FULL concurrent with adc_valid: sample ignored, ARM next cycle.
- Abort concurrent with pending wen: write completes, then readout owns.
- rd_addr → sram_addr combinational when readout owns.
- rst_n low mid-capture: immediate IDLE, wen/adc_en 0; release gives IDLE next edge.

## Structure
- Package capture_pkg: state encoding constants, DISCARD default, state width.
- One sub-module: capture_decimator (dec latch, dec_cnt, keep strobe); FSM, pointer, mux and edge detect in top.

## Test plan (ADDR_W=4, DISCARD=1)
- Reset release with start_lvl=1, valid each 4 cycles, dec=0, data=0x100+n → first sample dropped, 16 writes addr 0..15 data 0x101..0x110, full=1 cycle of last wen, adc_en=0.
- dec=2, continuous valid → every third sample written (data n=1,4,7,...), count=16 at FULL.
- FULL, start_lvl held high 50 cycles → stays FULL; toggle low/high → ARM, full=0, new capture overwrites addr 0.
- start_lvl falls after 5 writes → IDLE next cycle, adc_en=0, count=5, sram_addr tracks rd_addr, no further wen.
- rst_n low during CAPTURE with wen pending → sram_wen, adc_en, full, count all 0 immediately.
- Readout in FULL sweeping rd_addr 0..15 → sram_addr equals rd_addr each cycle, sram_wen stays 0.
